sd_adc_decim: RTL and testbench

//  FPGA-side controller for one external sigma-delta ADC channel (comparator + RC integrator).
//  - Samples the comparator bit `sd` and drives it back as the 1-bit feedback `pcm`.
//  - Decimates the bitstream with a boxcar filter (count-ones over a fixed window) into

---
 rtl/sd_adc_decim_if.sv | 28 ++
 rtl/sd_adc_decim.sv | 108 ++++++++++
 tb/tb_sd_adc_decim.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_adc_decim_if.sv
// Signal bundle between one sigma-delta channel controller and its consumer.
// Latency: none, wires only.
// Backpressure: none; samples are single-cycle pulses that the consumer must take.
interface sd_adc_decim_if #(
  parameter int W = 8
);
  logic         enable;
  logic         sd;
  logic         pcm;
  logic [W-1:0] sample;
  logic         sample_valid;
  logic [W-1:0] threshold;
  logic         arm;
  logic         trigger;
  logic [W-1:0] trig_sample;

  // Controller side: owns feedback, samples and trigger state.
  modport master (
    input  enable, sd, threshold, arm,
    output pcm, sample, sample_valid, trigger, trig_sample
  );

  // Consumer side: drives control and reads results.
  modport slave (
    output enable, sd, threshold, arm,
    input  pcm, sample, sample_valid, trigger, trig_sample
  );
endinterface

// File: rtl/sd_adc_decim.sv
// Sigma-delta ADC channel: sd synchroniser/feedback, boxcar decimator, armed threshold trigger.
// Latency: sd->pcm SYNC_STAGES clks; last window bit on pcm -> sample_valid 1 clk.
// Backpressure: none; sample_valid is a one-clock pulse every 2**OSR_LOG2 clks while accumulating.
module sd_adc_decim #(
  parameter int OSR_LOG2    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_WIN  = 2
) (
  input  logic           clk,
  input  logic           reset,
  sd_adc_decim_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0);

  logic [SYNC_STAGES-1:0] sync;
  logic                   pcm;
  state_t                 state;
  state_t                 state_nxt;
  logic [OSR_LOG2-1:0]    win_cnt;
  logic [OSR_LOG2:0]      ones;
  logic [OSR_LOG2:0]      ones_sum;
  logic [OSR_LOG2-1:0]    sat_sum;
  logic [3:0]             settle;
  logic                   win_end;
  logic                   armed;

  assign pcm      = sync[SYNC_STAGES-1];
  assign bus.pcm  = pcm;
  assign win_end  = (win_cnt == '1);
  // A full window of ones is one count past the sample range; clamp it to max.
  assign ones_sum = ones + (OSR_LOG2 + 1)'(pcm);
  assign sat_sum  = ones_sum[OSR_LOG2] ? '1 : ones_sum[OSR_LOG2-1:0];

  // Synchronise the comparator bit; the last stage doubles as the loop feedback.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], bus.sd};
  end

  // Decimator state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enable low always returns to IDLE, so a re-rise restarts settling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = (SETTLE_WIN > 0) ? SETTLE : ACCUM;
      SETTLE:  if (!bus.enable) state_nxt = IDLE;
               else if (win_end && settle == SETTLE_LAST) state_nxt = ACCUM;
      ACCUM:   if (!bus.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window counting and sample capture; a dropped enable discards the partial window.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt          <= '0;
      ones             <= '0;
      settle           <= '0;
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      if (state == IDLE || !bus.enable) begin
        win_cnt <= '0;
        ones    <= '0;
        settle  <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (win_end) begin
          ones <= '0;
          if (state == ACCUM) begin
            bus.sample       <= sat_sum;
            bus.sample_valid <= 1'b1;
          end else begin
            settle <= settle + 1'b1;
          end
        end else begin
          ones <= ones_sum;
        end
      end
    end
  end

  // Shot trigger: arm clears and re-arms (winning over a coincident sample); first armed hit sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed           <= 1'b0;
      bus.trigger     <= 1'b0;
      bus.trig_sample <= '0;
    end else if (bus.arm) begin
      armed       <= 1'b1;
      bus.trigger <= 1'b0;
    end else if (armed && bus.sample_valid && bus.sample >= bus.threshold) begin
      armed           <= 1'b0;
      bus.trigger     <= 1'b1;
      bus.trig_sample <= bus.sample;
    end
  end

endmodule

// File: tb/tb_sd_adc_decim.sv
// Bench for sd_adc_decim: randomized sd sources and control checked against a window-level model.
// Latency: model predicts outputs after each edge, compared on the following falling edge.
// Backpressure: none.
module tb_sd_adc_decim;

  localparam int W      = 8;
  localparam int SYNC   = 2;
  localparam int SETTLE = 2;
  localparam int WIN    = 1 << W;
  localparam int MAXV   = WIN - 1;

  logic clk = 1'b0;
  logic reset;

  sd_adc_decim_if #(.W(W)) bus ();

  sd_adc_decim #(.OSR_LOG2(W), .SYNC_STAGES(SYNC), .SETTLE_WIN(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // sd source: 0 random, 1 first-order modulator of adrv, 2 constant 1, 3 constant 0
  int        mode;
  int        adrv;
  int        mod_acc;

  // Reference model, expressed in windows counted from the enable edge.
  bit        m_pcm;
  bit        sdq[$];
  bit        m_run;
  int        m_n;
  int        m_acc;
  int        m_sample;
  bit        m_valid;
  bit        m_armed;
  bit        m_trig;
  int        m_tsamp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic gen_sd();
    int s;
    case (mode)
      0: bus.sd = 1'($urandom_range(1));
      1: begin
        s = mod_acc + adrv;
        bus.sd = (s >= 65536);
        mod_acc = s % 65536;
      end
      2: bus.sd = 1'b1;
      default: bus.sd = 1'b0;
    endcase
  endtask

  task automatic model_edge();
    bit nv;
    if (reset) begin
      sdq = {};
      for (int i = 0; i < SYNC - 1; i++) sdq.push_back(1'b0);
      m_pcm = 0; m_run = 0; m_n = 0; m_acc = 0; m_sample = 0; m_valid = 0;
      m_armed = 0; m_trig = 0; m_tsamp = 0;
      return;
    end
    if (bus.arm) begin
      m_armed = 1; m_trig = 0;
    end else if (m_armed && m_valid && m_sample >= int'(bus.threshold)) begin
      m_trig = 1; m_tsamp = m_sample; m_armed = 0;
    end
    nv = 0;
    if (!bus.enable) m_run = 0;
    else if (!m_run) begin
      m_run = 1; m_n = 0; m_acc = 0;
    end else begin
      m_n++;
      m_acc += int'(m_pcm);
      if (m_n % WIN == 0) begin
        if (m_n / WIN > SETTLE) begin
          m_sample = (m_acc > MAXV) ? MAXV : m_acc;
          nv = 1;
        end
        m_acc = 0;
      end
    end
    m_valid = nv;
    sdq.push_back(bus.sd);
    m_pcm = sdq.pop_front();
  endtask

  // One clock: drive sd, predict the edge, then compare away from it.
  task automatic tick();
    gen_sd();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("pcm",          bus.pcm,          m_pcm);
    check("sample_valid", bus.sample_valid, m_valid);
    check("sample",       bus.sample,       m_sample);
    check("trigger",      bus.trigger,      m_trig);
    check("trig_sample",  bus.trig_sample,  m_tsamp);
  endtask

  initial begin
    bit found;
    int en_off;
    reset = 1'b1;
    bus.enable = 1'b0; bus.arm = 1'b0; bus.threshold = '0; bus.sd = 1'b0;
    mode = 0; adrv = 32768; mod_acc = 0;

    // Reset held with a toggling comparator, then pcm tracks sd.
    repeat (5) tick();
    reset = 1'b0;
    repeat (40) tick();

    // Mid-scale input: settling, then regular ~128 samples.
    mode = 1; bus.enable = 1'b1;
    repeat (4000) tick();

    // Saturation at full scale, zero at empty.
    mode = 2; repeat (1000) tick();
    mode = 3; repeat (1000) tick();

    // Armed ramp towards full scale.
    mode = 1; adrv = 32768; bus.threshold = 8'd200;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      adrv = 32768 + (27232 * i) / 3000;
      tick();
    end
    repeat (600) tick();
    check("ramp_trig_set", bus.trigger, 1);
    check("ramp_tsamp_ge_thr", bus.trig_sample >= 8'd200, 1);

    // Arm landing on a qualifying sample pulse: arm wins, the next sample triggers.
    mode = 2; bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_valid) found = 1;
      else tick();
    end
    check("arm_pulse_seen", found, 1);
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    check("arm_wins", bus.trigger, 0);
    repeat (300) tick();
    check("next_sample_trig", bus.trigger, 1);

    // Drop enable 100 clocks into an accumulating window, then restart.
    mode = 1; adrv = 20000;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_run && m_n > 3 * WIN && m_n % WIN == 100) found = 1;
      else tick();
    end
    check("drop_point_seen", found, 1);
    bus.enable = 1'b0; repeat (50) tick();
    bus.enable = 1'b1; repeat (1200) tick();

    // Reset mid-window while enabled.
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_run && m_n > 3 * WIN && m_n % WIN == 150) found = 1;
      else tick();
    end
    check("reset_point_seen", found, 1);
    reset = 1'b1; repeat (3) tick(); reset = 1'b0;
    repeat (1200) tick();

    // Random soak across modes, levels, arm, threshold, enable and reset.
    en_off = 0;
    for (int i = 0; i < 12000; i++) begin
      if (i % 700 == 0) begin
        mode = $urandom_range(3);
        adrv = $urandom_range(65535);
      end
      if ($urandom_range(999) == 0) bus.threshold = 8'($urandom_range(255));
      bus.arm = ($urandom_range(399) == 0);
      if (en_off > 0) en_off--;
      else if ($urandom_range(1999) == 0) en_off = $urandom_range(300, 1);
      bus.enable = (en_off == 0);
      reset = ($urandom_range(5999) == 0);
      tick();
    end
    bus.arm = 1'b0; reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
